regfile_access_arbiter: RTL
===========================

// Module: regfile_access_arbiter
// PURPOSE
//  Shares one internal 8x16 register file (single port: one write OR one dual read
//  per enabled cycle, read data registered) between two requesters.
//  Round-robin arbitration; sequences each granted command through an FSM and
//  returns registered read data with a per-requester response strobe.
//  Sits between the execute-stage clients and the register file instance.
// PARAMETERS
//  DATA_W  16  register data width
//  ADDR_W  3   register address width (2**ADDR_W registers)
// PORTS
//  clock          in   1       rising-edge clock
//  reset_n        in   1       asynchronous active-low reset
//  reqN_valid     in   1       N=0,1: command valid
//  reqN_ready     out  1       N=0,1: command accepted this cycle when valid&ready
//  reqN_wr        in   1       1=write, 0=dual read
//  reqN_rd_adrs   in   ADDR_W  write address
//  reqN_ra_adrs   in   ADDR_W  read port A address
//  reqN_rb_adrs   in   ADDR_W  read port B address
//  reqN_data      in   DATA_W  write data
//  respN_valid    out  1       N=0,1: one-cycle strobe, read result for requester N
//  resp_ra        out  DATA_W  read A result (shared by both requesters)
//  resp_rb        out  DATA_W  read B result
//  rf_enable      out  1       register file enable
//  rf_wr_en       out  1       register file write enable
//  rf_rd_adrs     out  ADDR_W  register file write address
//  rf_ra_adrs     out  ADDR_W  register file read A address
//  rf_rb_adrs     out  ADDR_W  register file read B address
//  rf_data_in     out  DATA_W  register file write data
//  rf_ra_out      in   DATA_W  register file read A data (registered in file)
//  rf_rb_out      in   DATA_W  register file read B data
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, last_grant=1, all rf_* regs, resp_ra/rb,
//   respN_valid = 0; reqN_ready forced 0 while reset_n=0.
//  FSM: IDLE -> ISSUE -> (write) IDLE | (read) CAPT -> RESP -> IDLE.
//  IDLE: sel = only valid requester; both valid -> requester != last_grant.
//   reqN_ready = (state==IDLE) & (sel==N) & reqN_valid (combinational on valid).
//   Handshake at edge T: latch wr/addresses/data into rf_* regs, owner<=sel,
//   last_grant<=sel, go ISSUE. No valid: stay IDLE, rf_enable=0.
//   Requester holds valid and payload stable until ready.
//  ISSUE (T+1): rf_enable=1, rf_wr_en=latched wr; only state with rf_enable=1.
//   Write completes at end of T+1 with no response; next accept possible at T+2.
//  CAPT (T+2): rf_ra_out/rf_rb_out valid; latch into resp_ra/resp_rb.
//  RESP (T+3): resp<owner>_valid=1 exactly one cycle; other strobe 0; go IDLE.
//   Next accept at T+4. resp_ra/rb hold value until next CAPT.
//  rf_* address/data regs hold last command when not in ISSUE.
//  Ordering: write accepted at T is visible to any read accepted >= T+2.
//  ready never asserted outside IDLE; new valids wait without loss.
//  Reset mid-operation: in-flight command abandoned, no response issued,
//   rf_enable drops immediately; register file contents are not cleared.
//  Single requester valid continuously: served back-to-back, no fairness stall.
// STRUCTURE
//  Shared package: state encoding (IDLE/ISSUE/CAPT/RESP), DATA_W/ADDR_W defaults.
//  Sub-module rr_arbiter_2: valids + last_grant -> sel, any_valid (combinational).
//  Top: FSM, command latch, response regs, ready/strobe decode.
// TESTING
//  1 Reset: reset_n=0 with req0_valid=1 -> ready0=0, rf_enable=0, resp_*=0.
//  2 req0 write r3=0xBEEF accepted T -> rf_enable=1,rf_wr_en=1,rf_rd_adrs=3 at
//    T+1 only; then req0 read ra=3,rb=0 -> resp0_valid at accept+3, resp_ra=0xBEEF.
//  3 Both valid in IDLE after reset -> req0 granted first, req1 next, alternate
//    while both stay valid; resp strobes go to the matching requester.
//  4 req1 valid alone repeatedly (writes) -> accepted every 2 cycles.
//  5 Write r5=0x1234 then read r5 from other requester immediately -> 0x1234.
//  6 reset_n pulsed low in CAPT -> no respN_valid, state IDLE, next command ok.

Source files
------------

// File: rtl/regfile_access_arbiter_pkg.sv
// Shared types and default widths for the register-file access arbiter.
package regfile_access_arbiter_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 3;

    // Command sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_access_arbiter_rr.sv
// Two-way round-robin selector: picks the only valid requester, or the one
// that did not win last time when both are valid.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       sel_c,
    output logic       any_valid_c
);

    // Combinational grant selection
    always_comb begin
        any_valid_c = |valid;
        sel_c       = 1'b0;
        if (valid == 2'b11) begin
            sel_c = ~last_grant;
        end else if (valid[1]) begin
            sel_c = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares a single-port 8x16 register file between two requesters; sequences
// each granted command and returns registered read data with a response strobe.
module regfile_access_arbiter
    import regfile_access_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_rd_adrs,
    input  logic [ADDR_W-1:0] req0_ra_adrs,
    input  logic [ADDR_W-1:0] req0_rb_adrs,
    input  logic [DATA_W-1:0] req0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_rd_adrs,
    input  logic [ADDR_W-1:0] req1_ra_adrs,
    input  logic [ADDR_W-1:0] req1_rb_adrs,
    input  logic [DATA_W-1:0] req1_data,

    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_ra,
    output logic [DATA_W-1:0] resp_rb,

    output logic              rf_enable,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_rd_adrs,
    output logic [ADDR_W-1:0] rf_ra_adrs,
    output logic [ADDR_W-1:0] rf_rb_adrs,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_ra_out,
    input  logic [DATA_W-1:0] rf_rb_out
);

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic              sel_c;
    logic              any_valid_c;

    logic              sel_wr_c;
    logic [ADDR_W-1:0] sel_rd_adrs_c;
    logic [ADDR_W-1:0] sel_ra_adrs_c;
    logic [ADDR_W-1:0] sel_rb_adrs_c;
    logic [DATA_W-1:0] sel_data_c;

    rr_arbiter_2 u_rr (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .sel_c       (sel_c),
        .any_valid_c (any_valid_c)
    );

    // Payload of the currently selected requester
    always_comb begin
        sel_wr_c      = req0_wr;
        sel_rd_adrs_c = req0_rd_adrs;
        sel_ra_adrs_c = req0_ra_adrs;
        sel_rb_adrs_c = req0_rb_adrs;
        sel_data_c    = req0_data;
        if (sel_c) begin
            sel_wr_c      = req1_wr;
            sel_rd_adrs_c = req1_rd_adrs;
            sel_ra_adrs_c = req1_ra_adrs;
            sel_rb_adrs_c = req1_rb_adrs;
            sel_data_c    = req1_data;
        end
    end

    // Ready follows valid combinationally, only in IDLE and never during reset
    assign req0_ready = reset_n & (state == ST_IDLE) & ~sel_c & req0_valid;
    assign req1_ready = reset_n & (state == ST_IDLE) &  sel_c & req1_valid;

    // Command FSM: accept, issue to the file, capture read data, strobe response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            rf_enable   <= 1'b0;
            rf_wr_en    <= 1'b0;
            rf_rd_adrs  <= '0;
            rf_ra_adrs  <= '0;
            rf_rb_adrs  <= '0;
            rf_data_in  <= '0;
            resp_ra     <= '0;
            resp_rb     <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid_c) begin
                        rf_enable  <= 1'b1;
                        rf_wr_en   <= sel_wr_c;
                        rf_rd_adrs <= sel_rd_adrs_c;
                        rf_ra_adrs <= sel_ra_adrs_c;
                        rf_rb_adrs <= sel_rb_adrs_c;
                        rf_data_in <= sel_data_c;
                        owner      <= sel_c;
                        last_grant <= sel_c;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Writes finish here; reads wait one cycle for file output
                    rf_enable <= 1'b0;
                    rf_wr_en  <= 1'b0;
                    state     <= rf_wr_en ? ST_IDLE : ST_CAPT;
                end
                ST_CAPT: begin
                    resp_ra     <= rf_ra_out;
                    resp_rb     <= rf_rb_out;
                    resp0_valid <= ~owner;
                    resp1_valid <= owner;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    resp0_valid <= 1'b0;
                    resp1_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
